// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding and Morse timing constants for controlador_morse
package morse_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, GAP} state_t;
  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int ELEM_GAP_UNITS = 1;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;
  localparam int CODE_LEN       = 5;
  localparam int MAX_DIGIT      = 9;
endpackage

// File: rtl/gerador_unidade.sv
// gerador_unidade: per-unit tick and unit count (0..6), restarted by clear on each state entry
module gerador_unidade #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  output logic       tick,
  output logic [2:0] unit_cnt
);
  localparam int CW = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
  logic [CW-1:0] cyc;
  assign tick = cyc == CW'(UNIT_CYCLES - 1);
  // cycle counter wraps each unit; unit counter saturates at the longest gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc      <= '0;
      unit_cnt <= '0;
    end else if (clear) begin
      cyc      <= '0;
      unit_cnt <= '0;
    end else if (tick) begin
      cyc      <= '0;
      unit_cnt <= unit_cnt == 3'd6 ? unit_cnt : unit_cnt + 3'd1;
    end else begin
      cyc <= cyc + CW'(1);
    end
  end
endmodule

// File: rtl/controlador_morse.sv
// controlador_morse: digit handshake, encoder sequencing and Morse keying (word gap under MORSE_WORD_GAP_EN)
module controlador_morse
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] in_digit,
  input  logic       in_eow,
  input  logic       abort,
  output logic       in_ready,
  output logic [3:0] enc_bits,
  output logic       enc_ready,
  output logic       enc_reset,
  input  logic [4:0] enc_code,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       error
);
  state_t     state;
  logic [4:0] sh;
  logic [2:0] idx;
  logic       abort_q;
  logic       tick;
  logic [2:0] unit_cnt;
  logic [2:0] gap_u;
  logic [2:0] lim;
  logic       fin;
  logic       clr;
`ifdef MORSE_WORD_GAP_EN
  logic       eow_q;
`else
  logic       unused_eow;
  assign unused_eow = in_eow;
`endif

  assign in_ready  = reset_n && state == IDLE;
  assign busy      = state != IDLE;
  assign enc_reset = !reset_n || abort_q;

  gerador_unidade #(.UNIT_CYCLES(UNIT_CYCLES)) u_unit (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clr),
    .tick    (tick),
    .unit_cnt(unit_cnt)
  );

  // length of the current state in units and the edge that closes it
  always_comb begin
`ifdef MORSE_WORD_GAP_EN
    gap_u = eow_q ? 3'(WORD_GAP_UNITS) : 3'(CHAR_GAP_UNITS);
`else
    gap_u = 3'(CHAR_GAP_UNITS);
`endif
    lim = state == MARK ? (sh[4] ? 3'(DOT_UNITS) : 3'(DASH_UNITS)) :
          state == GAP  ? gap_u : 3'(ELEM_GAP_UNITS);
    fin = tick && unit_cnt == lim - 3'd1;
    clr = state == IDLE || state == LOAD || fin || abort;
  end

  // sequencer with registered outputs; abort outside IDLE overrides every transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sh        <= '0;
      idx       <= '0;
      abort_q   <= 1'b0;
      enc_bits  <= '0;
      enc_ready <= 1'b0;
      key_out   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
      eow_q     <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      error   <= 1'b0;
      abort_q <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        key_out   <= 1'b0;
        enc_ready <= 1'b0;
        abort_q   <= 1'b1;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            if (in_digit > 4'(MAX_DIGIT)) begin
              error <= 1'b1;
            end else begin
              enc_bits  <= in_digit;
              enc_ready <= 1'b1;
              state     <= LOAD;
`ifdef MORSE_WORD_GAP_EN
              eow_q     <= in_eow;
`endif
            end
          end
          LOAD: begin
            sh        <= enc_code;
            idx       <= '0;
            enc_ready <= 1'b0;
            key_out   <= 1'b1;
            state     <= MARK;
          end
          MARK: if (fin) begin
            key_out <= 1'b0;
            state   <= idx < 3'(CODE_LEN - 1) ? SPACE : GAP;
          end
          SPACE: if (fin) begin
            idx     <= idx + 3'd1;
            sh      <= {sh[3:0], 1'b0};
            key_out <= 1'b1;
            state   <= MARK;
          end
          GAP: if (fin) begin
            state <= IDLE;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/controlador_morse.md
# controlador_morse

Sequencer for the combinational binary-to-Morse encoder. It accepts one decimal digit at a time over a valid/ready handshake and drives the encoder's inputs, `ready` and `reset`. It captures the 5-element code and serialises it onto a single keying line with standard Morse timing (dot 1 unit, dash 3, element gap 1, character gap 3). It sits between the digit source and the keyer/LED output.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse time unit; legal range ≥1.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: digit offered.
- `in_digit` input 4: binary digit, MSB first (maps to encoder a,b,c,d).
- `in_eow` input 1: end-of-word flag, sampled with the digit. Used only under the macro.
- `abort` input 1: synchronous cancel of the current character.
- `in_ready` output 1: block can accept; high only in IDLE.
- `enc_bits` output 4: encoder inputs a,b,c,d.
- `enc_ready` output 1: encoder `ready`.
- `enc_reset` output 1: encoder `reset`, active-high.
- `enc_code` input 5: encoder outputs s1..s5 (bit4 = s1, sent first). 1 = dot, 0 = dash.
- `key_out` output 1: Morse keying, 1 = mark.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on character completion.
- `error` output 1: one-cycle pulse when a digit above 9 is rejected.

## Operation
- Reset values: `key_out` 0, `done` 0, `error` 0, `busy` 0, `enc_ready` 0, `enc_bits` 0, state IDLE, counters 0. `in_ready` is 0 while `reset_n` is low and 1 afterwards.
- `enc_reset` = ~`reset_n` OR (`abort` registered high for one cycle). It clears the encoder outputs.
- IDLE: handshake fires when `in_valid` and `in_ready` are both high.
  - If `in_digit` > 9: `error` pulses next cycle, the digit is dropped, and the block stays in IDLE.
  - Otherwise: latch the digit and eow, then go to LOAD.
- LOAD (1 cycle): `enc_ready`=1 and `enc_bits`=latched digit. At the closing edge, `enc_code` is captured into the 5-bit shift register, the element index is set to 0, and the state goes to MARK.
- MARK: `key_out`=1 for 1 unit if the current bit is 1, or 3 units if it is 0.
  - Then go to SPACE if index < 4, else go to GAP.
- SPACE: `key_out`=0 for 1 unit, index+1, shift register shifts left, then return to MARK.
- GAP: `key_out`=0 for 3 units (7 units when the macro is enabled and eow was latched). Then go to IDLE and pulse `done`.
- Unit timing: cycle counter 0..UNIT_CYCLES-1 and unit counter 0..6.
  - Both counters clear on every state entry.
  - A state ends when the unit counter reaches its limit and the cycle counter is at UNIT_CYCLES-1.
- `abort` high in any non-IDLE state:
  - next cycle: state IDLE, `key_out` 0, no `done`;
  - `enc_reset` pulses for 1 cycle.
  - `abort` in IDLE is ignored. When `abort` and `in_valid` are high together in IDLE, the digit is accepted.
- `enc_ready` is 0 outside LOAD. The encoder holds its last outputs, and those outputs are ignored.

## Timing
- Accept edge k, LOAD during cycle k+1, `key_out` first high in cycle k+2. All outputs are registered.
- Each mark or space lasts exactly N×UNIT_CYCLES cycles, with no gap cycles between states.
- Character length in units is dots + 3×dashes + 4 + 3 (or + 7 for a word gap):
  - digit 0: 22 units;
  - digit 1: 20 units;
  - digit 5: 12 units.
- `done` and `in_ready` rise in the same cycle, the first cycle of IDLE.
- Back-to-back characters: a new digit can be accepted in that same cycle, so there is zero idle overhead.
- `error` pulses in cycle k+1. `in_ready` stays high throughout.

## Configuration
- `MORSE_WORD_GAP_EN` defined: when `in_eow` was latched, GAP lasts 7 units.
- `MORSE_WORD_GAP_EN` undefined: `in_eow` is ignored and GAP is always 3 units. The port remains present.

## Structure
- Package `morse_pkg` holds:
  - the state enum (IDLE, LOAD, MARK, SPACE, GAP);
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, CODE_LEN=5, MAX_DIGIT=9.
- Sub-module `gerador_unidade` produces the per-unit tick and the unit count. It takes a `clear` input and the parameter UNIT_CYCLES.
- The encoder is instantiated by the parent, not inside this block.

## Test plan
1. UNIT_CYCLES=2, digit 1, encoder model attached → `key_out` pattern H2 L2 H6 L2 H6 L2 H6 L2 H6, then L6. `done` comes 40 cycles after the first high.
2. Digit 0 accepted, then digit 5 presented in the `done` cycle → 22 and 12 units sent contiguously, with `in_ready` low only during transmission.
3. Digit 12 → `error` for 1 cycle, `key_out` stays 0, `in_ready` stays 1, no `done`.
4. `abort` during the third MARK of digit 7 → `key_out` 0 and IDLE next cycle, `enc_reset` 1 for 1 cycle, no `done`.
5. `reset_n` low mid-dash → all outputs 0 immediately (asynchronous). After release, state is IDLE and `in_ready`=1.
6. With `MORSE_WORD_GAP_EN`, digit 9 and eow=1, UNIT_CYCLES=1 → trailing low lasts 7 cycles before `done`. Without the macro it lasts 3 cycles.
